// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a one-entry response register per requester. Optional stats: ALU_ARBITER_STATS_EN.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_FUNC3
`define LEN_FUNC3 3
`endif

module alu_arbiter (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [`LEN_FUNC3-1:0] req0_func3,
  input  logic                  req0_mode,
  input  logic [`LEN_WORD-1:0]  req0_rs1,
  input  logic [`LEN_WORD-1:0]  req0_rs2,
  output logic                  res0_valid,
  input  logic                  res0_ready,
  output logic [`LEN_WORD-1:0]  res0_rd,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [`LEN_FUNC3-1:0] req1_func3,
  input  logic                  req1_mode,
  input  logic [`LEN_WORD-1:0]  req1_rs1,
  input  logic [`LEN_WORD-1:0]  req1_rs2,
  output logic                  res1_valid,
  input  logic                  res1_ready,
  output logic [`LEN_WORD-1:0]  res1_rd,
  output logic [`LEN_FUNC3-1:0] alu_func3,
  output logic                  alu_mode_flag,
  output logic [`LEN_WORD-1:0]  alu_rs1,
  output logic [`LEN_WORD-1:0]  alu_rs2,
  input  logic [`LEN_WORD-1:0]  alu_rd
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_grant0,
  output logic [31:0]           stat_grant1,
  output logic [31:0]           stat_conflict
`endif
);

  logic                 last_grant_q, last_grant_d;
  logic                 res0_valid_q, res0_valid_d;
  logic                 res1_valid_q, res1_valid_d;
  logic [`LEN_WORD-1:0] res0_rd_q, res0_rd_d;
  logic [`LEN_WORD-1:0] res1_rd_q, res1_rd_d;
  logic                 elig0, elig1, grant0, grant1;

  // A slot can accept a new result if it is empty or being drained this cycle.
  assign elig0  = req0_valid && (!res0_valid_q || res0_ready);
  assign elig1  = req1_valid && (!res1_valid_q || res1_ready);
  assign grant0 = elig0 && (!elig1 || last_grant_q);
  assign grant1 = elig1 && (!elig0 || !last_grant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res0_rd    = res0_rd_q;
  assign res1_rd    = res1_rd_q;

  always_comb begin
    alu_func3     = '0;
    alu_mode_flag = 1'b0;
    alu_rs1       = '0;
    alu_rs2       = '0;
    if (grant0) begin
      alu_func3     = req0_func3;
      alu_mode_flag = req0_mode;
      alu_rs1       = req0_rs1;
      alu_rs2       = req0_rs2;
    end else if (grant1) begin
      alu_func3     = req1_func3;
      alu_mode_flag = req1_mode;
      alu_rs1       = req1_rs1;
      alu_rs2       = req1_rs2;
    end
  end

  always_comb begin
    res0_valid_d = res0_valid_q;
    res0_rd_d    = res0_rd_q;
    res1_valid_d = res1_valid_q;
    res1_rd_d    = res1_rd_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      res0_valid_d = 1'b1;
      res0_rd_d    = alu_rd;
      last_grant_d = 1'b0;
    end else if (res0_valid_q && res0_ready) begin
      res0_valid_d = 1'b0;
    end
    if (grant1) begin
      res1_valid_d = 1'b1;
      res1_rd_d    = alu_rd;
      last_grant_d = 1'b1;
    end else if (res1_valid_q && res1_ready) begin
      res1_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_rd_q    <= '0;
      res1_rd_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_rd_q    <= res0_rd_d;
      res1_rd_q    <= res1_rd_d;
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  logic [31:0] stat_grant0_q, stat_grant0_d;
  logic [31:0] stat_grant1_q, stat_grant1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  // Counters saturate rather than wrap.
  always_comb begin
    stat_grant0_d   = stat_grant0_q;
    stat_grant1_d   = stat_grant1_q;
    stat_conflict_d = stat_conflict_q;
    if (grant0 && (stat_grant0_q != 32'hFFFF_FFFF))
      stat_grant0_d = stat_grant0_q + 32'd1;
    if (grant1 && (stat_grant1_q != 32'hFFFF_FFFF))
      stat_grant1_d = stat_grant1_q + 32'd1;
    if (elig0 && elig1 && (stat_conflict_q != 32'hFFFF_FFFF))
      stat_conflict_d = stat_conflict_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_grant0_q   <= stat_grant0_d;
      stat_grant1_q   <= stat_grant1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
